spi_slave_axi_bridge_v2: RTL

SPI_SLAVE_AXI_BRIDGE_V2 -- requirements
Module: spi_slave_axi_bridge_v2

---
 rtl/spi_slave_axi_bridge_v2.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_axi_bridge_v2.sv
// spi_slave_axi_bridge_v2: SPI word streams to single-beat AXI4 writes and reads with independent write/read address pointers.
module spi_slave_axi_bridge_v2 #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH = 3,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID = 1
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  output logic                        axi_master_aw_valid,
  input  logic                        axi_master_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr,
  output logic [2:0]                  axi_master_aw_prot,
  output logic [3:0]                  axi_master_aw_region,
  output logic [7:0]                  axi_master_aw_len,
  output logic [2:0]                  axi_master_aw_size,
  output logic [1:0]                  axi_master_aw_burst,
  output logic                        axi_master_aw_lock,
  output logic [3:0]                  axi_master_aw_cache,
  output logic [3:0]                  axi_master_aw_qos,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user,
  output logic                        axi_master_w_valid,
  input  logic                        axi_master_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb,
  output logic                        axi_master_w_last,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_w_user,
  input  logic                        axi_master_b_valid,
  output logic                        axi_master_b_ready,
  input  logic [1:0]                  axi_master_b_resp,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_b_id,
  input  logic [AXI_USER_WIDTH-1:0]   axi_master_b_user,
  output logic                        axi_master_ar_valid,
  input  logic                        axi_master_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr,
  output logic [2:0]                  axi_master_ar_prot,
  output logic [3:0]                  axi_master_ar_region,
  output logic [7:0]                  axi_master_ar_len,
  output logic [2:0]                  axi_master_ar_size,
  output logic [1:0]                  axi_master_ar_burst,
  output logic                        axi_master_ar_lock,
  output logic [3:0]                  axi_master_ar_cache,
  output logic [3:0]                  axi_master_ar_qos,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user,
  input  logic                        axi_master_r_valid,
  output logic                        axi_master_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_master_r_data,
  input  logic [1:0]                  axi_master_r_resp,
  input  logic                        axi_master_r_last,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_r_id,
  input  logic [AXI_USER_WIDTH-1:0]   axi_master_r_user,
  input  logic [31:0]                 rxtx_addr,
  input  logic                        rxtx_addr_valid,
  input  logic                        start_tx,
  input  logic                        cs,
  input  logic [31:0]                 rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [31:0]                 tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        err_o
);
  localparam int NL = AXI_DATA_WIDTH / 32;
  localparam int LW = NL > 1 ? $clog2(NL) : 1;
  localparam int SW = AXI_DATA_WIDTH / 8;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_TX} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr, load_addr;
  logic [31:0] wr_word;
  logic [LW-1:0] wr_lane, rd_lane;
  logic abort, b_err, r_err, unused;
  assign load_addr = AXI_ADDR_WIDTH'(rxtx_addr);
  assign wr_lane = NL > 1 ? wr_addr[LW+1:2] : '0;
  assign rd_lane = NL > 1 ? rd_addr[LW+1:2] : '0;
  assign axi_master_aw_addr = wr_addr;
  assign axi_master_ar_addr = rd_addr;
  assign axi_master_w_data = {NL{wr_word}};
  assign axi_master_w_strb = SW'(4'hF) << (4 * wr_lane);
  assign axi_master_w_last = 1'b1;
  assign axi_master_w_user = '0;
  assign axi_master_aw_prot = '0;
  assign axi_master_aw_region = '0;
  assign axi_master_aw_len = '0;
  assign axi_master_aw_size = 3'b010;
  assign axi_master_aw_burst = 2'b01;
  assign axi_master_aw_lock = 1'b0;
  assign axi_master_aw_cache = '0;
  assign axi_master_aw_qos = '0;
  assign axi_master_aw_id = AXI_ID_WIDTH'(AXI_ID);
  assign axi_master_aw_user = '0;
  assign axi_master_ar_prot = '0;
  assign axi_master_ar_region = '0;
  assign axi_master_ar_len = '0;
  assign axi_master_ar_size = 3'b010;
  assign axi_master_ar_burst = 2'b01;
  assign axi_master_ar_lock = 1'b0;
  assign axi_master_ar_cache = '0;
  assign axi_master_ar_qos = '0;
  assign axi_master_ar_id = AXI_ID_WIDTH'(AXI_ID);
  assign axi_master_ar_user = '0;
  assign unused = ^{axi_master_r_last, axi_master_r_id, axi_master_r_user, axi_master_b_id, axi_master_b_user};
  assign b_err = w_state == W_RESP && axi_master_b_valid && axi_master_b_resp != 2'b00;
  assign r_err = r_state == R_DATA && axi_master_r_valid && axi_master_r_resp != 2'b00;
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      w_state <= W_IDLE;
      rx_ready <= 1'b0;
      axi_master_aw_valid <= 1'b0;
      axi_master_w_valid <= 1'b0;
      axi_master_b_ready <= 1'b0;
      wr_word <= '0;
      wr_addr <= '0;
    end else begin
      case (w_state)
        W_IDLE:
          if (rx_valid && rx_ready) begin
            wr_word <= rx_data;
            rx_ready <= 1'b0;
            axi_master_aw_valid <= 1'b1;
            axi_master_w_valid <= 1'b1;
            w_state <= W_REQ;
          end else rx_ready <= 1'b1;
        W_REQ: begin
          if (axi_master_aw_ready) axi_master_aw_valid <= 1'b0;
          if (axi_master_w_ready) axi_master_w_valid <= 1'b0;
          if ((!axi_master_aw_valid || axi_master_aw_ready) && (!axi_master_w_valid || axi_master_w_ready)) begin
            axi_master_b_ready <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP:
          if (axi_master_b_valid) begin
            axi_master_b_ready <= 1'b0;
            rx_ready <= 1'b1;
            wr_addr <= wr_addr + AXI_ADDR_WIDTH'(4);
            w_state <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase
      if (rxtx_addr_valid) wr_addr <= load_addr;
    end
  // cs during an outstanding read only marks it; the AXI transfer still completes and its data is dropped
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      r_state <= R_IDLE;
      axi_master_ar_valid <= 1'b0;
      axi_master_r_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      rd_addr <= '0;
      abort <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE:
          if (start_tx && !cs) begin
            axi_master_ar_valid <= 1'b1;
            r_state <= R_ADDR;
          end
        R_ADDR: begin
          if (cs) abort <= 1'b1;
          if (axi_master_ar_ready) begin
            axi_master_ar_valid <= 1'b0;
            axi_master_r_ready <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA:
          if (axi_master_r_valid) begin
            axi_master_r_ready <= 1'b0;
            abort <= 1'b0;
            if (abort || cs) r_state <= R_IDLE;
            else begin
              tx_data <= axi_master_r_data[32*rd_lane +: 32];
              tx_valid <= 1'b1;
              r_state <= R_TX;
            end
          end else if (cs) abort <= 1'b1;
        R_TX:
          if (cs) begin
            tx_valid <= 1'b0;
            r_state <= R_IDLE;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            rd_addr <= rd_addr + AXI_ADDR_WIDTH'(4);
            axi_master_ar_valid <= 1'b1;
            r_state <= R_ADDR;
          end
        default: r_state <= R_IDLE;
      endcase
      if (rxtx_addr_valid) rd_addr <= load_addr;
    end
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) err_o <= 1'b0;
    else if (b_err || r_err) err_o <= 1'b1;
    else if (rxtx_addr_valid) err_o <= 1'b0;
endmodule
